// File: rtl/dual_core_mem_arbiter_pkg.sv
// dcma_pkg: shared types and constants for the dual-core memory arbiter.
//   state_t   : access FSM states
//   DEPTH_DEF : default memory depth (words), IDX_W its word-index width
//   CNT_W     : latency counter width (LAT up to 15)
//   CORE1/2   : core-id encoding used by owner, rr pointer and winner id
package dcma_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int DEPTH_DEF = 128;
    localparam int IDX_W     = $clog2(DEPTH_DEF);
    localparam int CNT_W     = 4;

    localparam logic CORE1 = 1'b0;
    localparam logic CORE2 = 1'b1;
endpackage

// File: rtl/dual_core_mem_arbiter_if.sv
// dual_core_mem_arbiter_if: per-core MemRead/MemWrite/addr/data request bus
// of the two Pipe_CPU_1 cores, with the returned read data and stall.
//   slave  : arbiter side (requests in, data/stall out)
//   master : core side (requests out, data/stall in)
interface dual_core_mem_arbiter_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] addr_i1, data_i1, data_o1;
    logic              MemRead_i1, MemWrite_i1, stall_o1;
    logic [DATA_W-1:0] addr_i2, data_i2, data_o2;
    logic              MemRead_i2, MemWrite_i2, stall_o2;

    modport slave (
        input  addr_i1, data_i1, MemRead_i1, MemWrite_i1,
        input  addr_i2, data_i2, MemRead_i2, MemWrite_i2,
        output data_o1, stall_o1, data_o2, stall_o2
    );
    modport master (
        output addr_i1, data_i1, MemRead_i1, MemWrite_i1,
        output addr_i2, data_i2, MemRead_i2, MemWrite_i2,
        input  data_o1, stall_o1, data_o2, stall_o2
    );
endinterface

// File: rtl/dual_core_mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-requester round-robin arbiter.
//   req_i[1:0] : request per core (bit 0 = core 1)
//   ptr_i      : core favoured when both request
//   gnt_o[1:0] : one-hot grant, zero when nobody requests
//   win_o      : id of the granted core (meaningful only when gnt_o != 0)
module rr_arb2
    import dcma_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       win_o
);
    always_comb begin
        win_o = CORE1;
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   win_o = CORE1;
            2'b10:   win_o = CORE2;
            2'b11:   win_o = ptr_i;
            default: win_o = CORE1;
        endcase
        if (req_i != 2'b00)
            gnt_o = (win_o == CORE2) ? 2'b10 : 2'b01;
    end
endmodule

// File: rtl/dual_core_mem_arbiter.sv
// dual_core_mem_arbiter: shared data memory for two cores, one access at a
// time with LAT cycles in BUSY, round-robin between contending cores.
//   clk_i, rst_n : clock, asynchronous active-low reset
//   bus          : per-core request bus (slave side)
//   busy_o       : FSM not in IDLE
//   owner_o      : core being served (0 = core 1), valid while busy_o
module dual_core_mem_arbiter
    import dcma_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int LAT    = 2
)(
    input  logic                    clk_i,
    input  logic                    rst_n,
    dual_core_mem_arbiter_if.slave  bus,
    output logic                    busy_o,
    output logic                    owner_o
);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic              rr_q, owner_q, busy_q, wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, data1_q, data2_q;
    logic              wr_d;
    logic [1:0]        req, gnt;
    logic              win;

    assign req = {bus.MemRead_i2 | bus.MemWrite_i2, bus.MemRead_i1 | bus.MemWrite_i1};

    rr_arb2 u_arb (.req_i(req), .ptr_i(rr_q), .gnt_o(gnt), .win_o(win));

    // Access captured at grant; read+write together decodes as a write.
    always_comb begin
        idx_d   = (win == CORE2) ? bus.addr_i2[IW+1:2] : bus.addr_i1[IW+1:2];
        wdata_d = (win == CORE2) ? bus.data_i2 : bus.data_i1;
        wr_d    = (win == CORE2) ? bus.MemWrite_i2 : bus.MemWrite_i1;
    end

    // Byte offset and high (aliasing) address bits are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{bus.addr_i1[DATA_W-1:IW+2], bus.addr_i1[1:0],
                           bus.addr_i2[DATA_W-1:IW+2], bus.addr_i2[1:0]};

    logic last_beat;
    assign last_beat = (state_q == BUSY) && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= CORE1;
            owner_q <= CORE1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt != 2'b00) begin
                    owner_q <= win;
                    idx_q   <= idx_d;
                    wdata_q <= wdata_d;
                    wr_q    <= wr_d;
                    cnt_q   <= CNT_W'(LAT - 1);
                    busy_q  <= 1'b1;
                    state_q <= BUSY;
                end
                BUSY: if (cnt_q == '0) begin
                    state_q <= DONE;
                    if (!wr_q) begin
                        if (owner_q == CORE2) data2_q <= mem[idx_q];
                        else                  data1_q <= mem[idx_q];
                    end
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    rr_q    <= ~owner_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory is not reset; a reset before the last BUSY edge drops the write.
    always_ff @(posedge clk_i) begin
        if (last_beat && wr_q)
            mem[idx_q] <= wdata_q;
    end

    // A core stalls while requesting, except in its own DONE cycle.
    assign bus.stall_o1 = req[0] & ~((state_q == DONE) && (owner_q == CORE1));
    assign bus.stall_o2 = req[1] & ~((state_q == DONE) && (owner_q == CORE2));
    assign bus.data_o1  = data1_q;
    assign bus.data_o2  = data2_q;
    assign busy_o       = busy_q;
    assign owner_o      = owner_q;
endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
module tb_dual_core_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, owner;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dual_core_mem_arbiter_if #(.DATA_W(32)) bus ();

    dual_core_mem_arbiter #(.DATA_W(32), .DEPTH(128), .LAT(2)) dut (
        .clk_i(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy), .owner_o(owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All activity happens 1 time unit after a falling edge.
    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic drive(input int core, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (core == 1) begin
            bus.MemRead_i1 = rd; bus.MemWrite_i1 = wr; bus.addr_i1 = addr; bus.data_i1 = wd;
        end else begin
            bus.MemRead_i2 = rd; bus.MemWrite_i2 = wr; bus.addr_i2 = addr; bus.data_i2 = wd;
        end
    endtask

    // Single access by one core; counts stalled cycles, returns data_o in the DONE cycle.
    task automatic access(input int core, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, output int nstall, output logic [31:0] rd);
        nstall = 0;
        drive(core, !wr, wr, addr, wd);
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((core == 1) ? bus.stall_o1 : bus.stall_o2) begin
                nstall++;
                tick();
            end else break;
        end
        rd = (core == 1) ? bus.data_o1 : bus.data_o2;
        tick();
        drive(core, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int          ns;
        logic [31:0] rd;
        logic        prev_busy;
        int          ng;
        int          gcyc [16];
        logic        gown [16];

        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("rst_busy",   {31'b0, busy},  32'h0);
        chk("rst_owner",  {31'b0, owner}, 32'h0);
        chk("rst_data1",  bus.data_o1,    32'h0);
        chk("rst_data2",  bus.data_o2,    32'h0);
        chk("rst_stall1", {31'b0, bus.stall_o1}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write then read by core 1.
        access(1, 1'b1, 32'h10, 32'hAA, ns, rd);
        chk("wr_stall_cycles", ns, 3);
        access(1, 1'b0, 32'h10, 32'h0, ns, rd);
        chk("rd_stall_cycles", ns, 3);
        chk("rd_data_aa", rd, 32'hAA);

        // Simultaneous writes after reset: core 1 first, then core 2.
        do_reset();
        drive(1, 1'b0, 1'b1, 32'h0, 32'd5);
        drive(2, 1'b0, 1'b1, 32'h4, 32'd7);
        #1;
        chk("sim_c1_stall1", {31'b0, bus.stall_o1}, 32'h1);
        chk("sim_c1_stall2", {31'b0, bus.stall_o2}, 32'h1);
        chk("sim_c1_busy",   {31'b0, busy}, 32'h0);
        tick();
        chk("sim_c2_busy",  {31'b0, busy},  32'h1);
        chk("sim_c2_owner", {31'b0, owner}, 32'h0);
        tick(); tick();
        chk("sim_c4_stall1", {31'b0, bus.stall_o1}, 32'h0);
        chk("sim_c4_stall2", {31'b0, bus.stall_o2}, 32'h1);
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("sim_c5_busy",   {31'b0, busy}, 32'h0);
        chk("sim_c5_stall2", {31'b0, bus.stall_o2}, 32'h1);
        tick();
        chk("sim_c6_owner", {31'b0, owner}, 32'h1);
        chk("sim_c6_busy",  {31'b0, busy},  32'h1);
        tick();
        chk("sim_c7_stall2", {31'b0, bus.stall_o2}, 32'h1);
        tick();
        chk("sim_c8_stall2", {31'b0, bus.stall_o2}, 32'h0);
        tick();
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        access(1, 1'b0, 32'h0, 32'h0, ns, rd);
        chk("sim_m0", rd, 32'd5);
        access(2, 1'b0, 32'h4, 32'h0, ns, rd);
        chk("sim_m1", rd, 32'd7);

        // Same-address race on 0x8: core 1 then core 2, later write wins.
        do_reset();
        drive(1, 1'b0, 1'b1, 32'h8, 32'd1);
        drive(2, 1'b0, 1'b1, 32'h8, 32'd2);
        tick();
        chk("race_first_owner", {31'b0, owner}, 32'h0);
        tick(); tick(); tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("race_second_owner", {31'b0, owner}, 32'h1);
        tick(); tick();
        chk("race_c2_done", {31'b0, bus.stall_o2}, 32'h0);
        tick();
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        access(1, 1'b0, 32'h8, 32'h0, ns, rd);
        chk("race_mem2", rd, 32'd2);

        // Continuous contention: both cores read for 20 cycles.
        do_reset();
        drive(1, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b1, 1'b0, 32'h4, 32'h0);
        #1;
        ng = 0;
        prev_busy = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (busy && !prev_busy && ng < 16) begin
                gcyc[ng] = c;
                gown[ng] = owner;
                ng++;
            end
            prev_busy = busy;
            if (c < 20) tick();
        end
        tick();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("cont_grants", ng, 5);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("cont_owner%0d", i), {31'b0, gown[i]}, i % 2);
            if (i > 0) chk($sformatf("cont_gap%0d", i), gcyc[i] - gcyc[i-1], 4);
        end
        for (int i = 0; i < 10 && busy; i++) tick();
        chk("cont_drained", {31'b0, busy}, 32'h0);
        chk("cont_data2", bus.data_o2, 32'd7);

        // Aliasing: 0x203 maps to word 0 with DEPTH=128.
        access(1, 1'b1, 32'h203, 32'd9, ns, rd);
        access(1, 1'b0, 32'h000, 32'h0, ns, rd);
        chk("alias_data", rd, 32'd9);
        chk("hold_data2", bus.data_o2, 32'd7);

        // Reset mid-BUSY of a write of 3 over a previous 4 at 0x20.
        access(1, 1'b1, 32'h20, 32'd4, ns, rd);
        drive(1, 1'b0, 1'b1, 32'h20, 32'd3);
        tick();
        chk("midrst_busy_before", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("midrst_busy",   {31'b0, busy}, 32'h0);
        chk("midrst_stall1", {31'b0, bus.stall_o1}, 32'h0);
        chk("midrst_stall2", {31'b0, bus.stall_o2}, 32'h0);
        chk("midrst_data1",  bus.data_o1, 32'h0);
        chk("midrst_data2",  bus.data_o2, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        access(1, 1'b0, 32'h20, 32'h0, ns, rd);
        chk("midrst_read_old", rd, 32'd4);
        chk("midrst_rd_stalls", ns, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
